// File: rtl/hist2d_bin_in_capture.sv
`default_nettype none
// ============================================================================
// hist2d_bin_in_capture : buffers streamed (i,q,value) bins, accumulates in BRAM
// Revision 1.0
// ============================================================================
module hist2d_bin_in_capture #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int COORD_W    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk100,
  input  logic               reset_n,
  input  logic               start_capture,
  input  logic [COORD_W-1:0] i_bin_num,
  input  logic [COORD_W-1:0] q_bin_num,
  input  logic               data_in,
  input  logic [DATA_W-1:0]  bin_val,
  input  logic [COORD_W-1:0] i_bin_in,
  input  logic [COORD_W-1:0] q_bin_in,
  input  logic [DATA_W-1:0]  mem_read_val,
  output logic [ADDR_W-1:0]  mem_address,
  output logic               mem_write,
  output logic               mem_reset,
  output logic [DATA_W-1:0]  mem_write_val,
  output logic               busy,
  output logic               capture_done,
  output logic [ADDR_W-1:0]  bins_received,
  output logic [31:0]        total_count,
  output logic               overflow_err,
  output logic               range_err,
  output logic               sat_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LIN_W = (ADDR_W > 2*COORD_W+1) ? ADDR_W : 2*COORD_W+1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_WRITE = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]        r_state, w_next;
  logic [PTR_W:0]    r_wr_ptr, r_rd_ptr;
  logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] r_fifo_val  [FIFO_DEPTH];
  logic [ADDR_W-1:0] r_addr, r_bins;
  logic [DATA_W-1:0] r_val;
  logic [31:0]       r_total;
  logic              r_ovf, r_rng, r_sat;

  logic              w_run, w_empty, w_full, w_in_range, w_push, w_all_in, w_sat;
  logic [LIN_W-1:0]  w_lin, w_target;
  logic [ADDR_W-1:0] w_push_addr, w_head_addr;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W-1:0] w_wr_val;

  assign w_run = (r_state == S_RUN) || (r_state == S_READ) ||
                 (r_state == S_WAIT) || (r_state == S_WRITE);
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_in_range = (i_bin_in < i_bin_num) && (q_bin_in < q_bin_num);
  assign w_push     = w_run && data_in && w_in_range && !w_full;

  // Address is linearised at push time so the FIFO only carries addr/value.
  assign w_lin       = LIN_W'(q_bin_in) * LIN_W'(i_bin_num) + LIN_W'(i_bin_in);
  assign w_push_addr = w_lin[ADDR_W-1:0];
  assign w_target    = LIN_W'(i_bin_num) * LIN_W'(q_bin_num);
  assign w_all_in    = (LIN_W'(r_bins) == w_target);
  assign w_head_addr = r_fifo_addr[r_rd_ptr[PTR_W-1:0]];

  assign w_sum    = {1'b0, mem_read_val} + {1'b0, r_val};
  assign w_sat    = w_sum[DATA_W];
  assign w_wr_val = w_sat ? {DATA_W{1'b1}} : w_sum[DATA_W-1:0];

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start_capture) w_next = S_CLEAR;
      S_CLEAR: w_next = (w_target == '0) ? S_DONE : S_RUN;
      S_RUN:   if (!w_empty) w_next = S_READ;
               else if (w_all_in) w_next = S_DONE;
      S_READ:  w_next = S_WAIT;
      S_WAIT:  w_next = S_WRITE;
      S_WRITE: w_next = w_empty ? S_RUN : S_READ;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk100) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr[PTR_W-1:0]] <= w_push_addr;
      r_fifo_val[r_wr_ptr[PTR_W-1:0]]  <= bin_val;
    end
  end

  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_addr   <= '0;
      r_val    <= '0;
      r_bins   <= '0;
      r_total  <= '0;
      r_ovf    <= 1'b0;
      r_rng    <= 1'b0;
      r_sat    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && start_capture) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_bins   <= '0;
        r_total  <= '0;
        r_ovf    <= 1'b0;
        r_rng    <= 1'b0;
        r_sat    <= 1'b0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
          r_bins   <= r_bins + 1'b1;
          r_total  <= r_total + 32'(bin_val);
        end
        if (w_run && data_in && !w_in_range) r_rng <= 1'b1;
        if (w_run && data_in && w_in_range && w_full) r_ovf <= 1'b1;
        if (r_state == S_READ) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
          r_addr   <= w_head_addr;
          r_val    <= r_fifo_val[r_rd_ptr[PTR_W-1:0]];
        end
        if (r_state == S_WRITE && w_sat) r_sat <= 1'b1;
      end
    end
  end

  always_comb begin
    mem_address = '0;
    if (r_state == S_READ) mem_address = w_head_addr;
    else if (r_state == S_WAIT || r_state == S_WRITE) mem_address = r_addr;
  end

  assign mem_write     = (r_state == S_WRITE);
  assign mem_reset     = (r_state == S_CLEAR);
  assign mem_write_val = (r_state == S_WRITE) ? w_wr_val : '0;
  assign busy          = w_run || (r_state == S_CLEAR);
  assign capture_done  = (r_state == S_DONE);
  assign bins_received = r_bins;
  assign total_count   = r_total;
  assign overflow_err  = r_ovf;
  assign range_err     = r_rng;
  assign sat_err       = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_hist2d_bin_in_capture.sv
`default_nettype none
// ============================================================================
// tb_hist2d_bin_in_capture : directed + randomized bench with a BRAM model
// Revision 1.0
// ============================================================================
module tb_hist2d_bin_in_capture;

  logic        clk100 = 1'b0;
  logic        reset_n = 1'b1;
  logic        start_capture = 1'b0;
  logic [7:0]  i_bin_num = '0, q_bin_num = '0, i_bin_in = '0, q_bin_in = '0;
  logic        data_in = 1'b0;
  logic [15:0] bin_val = '0;
  logic [15:0] mem_read_val;
  logic [15:0] mem_address, mem_write_val, bins_received;
  logic        mem_write, mem_reset, busy, capture_done;
  logic [31:0] total_count;
  logic        overflow_err, range_err, sat_err;

  hist2d_bin_in_capture #(.DATA_W(16), .ADDR_W(16), .COORD_W(8), .FIFO_DEPTH(4)) dut (
    .clk100(clk100), .reset_n(reset_n), .start_capture(start_capture),
    .i_bin_num(i_bin_num), .q_bin_num(q_bin_num), .data_in(data_in),
    .bin_val(bin_val), .i_bin_in(i_bin_in), .q_bin_in(q_bin_in),
    .mem_read_val(mem_read_val), .mem_address(mem_address), .mem_write(mem_write),
    .mem_reset(mem_reset), .mem_write_val(mem_write_val), .busy(busy),
    .capture_done(capture_done), .bins_received(bins_received),
    .total_count(total_count), .overflow_err(overflow_err),
    .range_err(range_err), .sat_err(sat_err)
  );

  always #5 clk100 = ~clk100;

  // BRAM model: synchronous read, clear-all, write, and a bench preload port.
  logic [15:0] mem [256];
  logic        pre_en = 1'b0;
  logic [7:0]  pre_addr = '0;
  logic [15:0] pre_val = '0;
  always @(posedge clk100) begin
    mem_read_val <= mem[mem_address[7:0]];
    if (mem_reset) begin
      for (int k = 0; k < 256; k++) mem[k] <= '0;
    end else if (mem_write) mem[mem_address[7:0]] <= mem_write_val;
    else if (pre_en) mem[pre_addr] <= pre_val;
  end

  int          n_wr = 0, n_done = 0, n_both = 0;
  logic [15:0] last_wr_addr = '0, last_wr_val = '0;
  always @(posedge clk100) begin
    if (mem_write) begin
      n_wr         <= n_wr + 1;
      last_wr_addr <= mem_address;
      last_wr_val  <= mem_write_val;
    end
    if (mem_write && mem_reset) n_both <= n_both + 1;
    if (capture_done) n_done <= n_done + 1;
  end

  int errors = 0, checks = 0;

  // Reference model of the accumulated histogram.
  int          ibn, qbn, exp_bins;
  logic [31:0] exp_total;
  logic [15:0] exp_mem [256];
  bit          exp_sat, exp_rng;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk100);
    #1;
  endtask

  task automatic model_start(input int ni, input int nq);
    ibn = ni; qbn = nq; exp_bins = 0; exp_total = 0; exp_sat = 0; exp_rng = 0;
    for (int k = 0; k < 256; k++) exp_mem[k] = '0;
  endtask

  task automatic model_tuple(input int i, input int q, input int v);
    int a, s;
    if (i < ibn && q < qbn) begin
      a = q * ibn + i;
      s = int'(exp_mem[a]) + v;
      if (s > 65535) begin s = 65535; exp_sat = 1; end
      exp_mem[a] = 16'(s);
      exp_bins++;
      exp_total += 32'(v);
    end else exp_rng = 1;
  endtask

  task automatic start(input int ni, input int nq);
    i_bin_num = 8'(ni); q_bin_num = 8'(nq);
    start_capture = 1'b1;
    tick();
    start_capture = 1'b0;
    model_start(ni, nq);
  endtask

  task automatic send(input int i, input int q, input int v);
    data_in = 1'b1; i_bin_in = 8'(i); q_bin_in = 8'(q); bin_val = 16'(v);
    tick();
    data_in = 1'b0;
  endtask

  task automatic send_m(input int i, input int q, input int v, input int gap);
    model_tuple(i, q, v);
    send(i, q, v);
    repeat (gap) tick();
  endtask

  task automatic preload(input int a, input int v);
    pre_en = 1'b1; pre_addr = 8'(a); pre_val = 16'(v);
    tick();
    pre_en = 1'b0;
    exp_mem[a] = 16'(v);
  endtask

  task automatic wait_done(input string tag);
    bit seen = 0;
    for (int c = 0; c < 300 && !seen; c++) begin
      if (capture_done) seen = 1;
      else tick();
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    tick();
  endtask

  task automatic check_all(input string tag);
    for (int a = 0; a < ibn * qbn; a++) chk($sformatf("%s_bin%0d", tag, a), 64'(mem[a]), 64'(exp_mem[a]));
    chk({tag, "_bins"}, 64'(bins_received), 64'(exp_bins));
    chk({tag, "_total"}, 64'(total_count), 64'(exp_total));
    chk({tag, "_sat"}, 64'(sat_err), 64'(exp_sat));
    chk({tag, "_rng"}, 64'(range_err), 64'(exp_rng));
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_outs"}, 64'({mem_address, mem_write, mem_reset, mem_write_val, busy,
        capture_done, bins_received, overflow_err, range_err, sat_err}), 64'd0);
    chk({tag, "_total"}, 64'(total_count), 64'd0);
  endtask

  initial begin
    int d0, w0, ni, nq, v;
    bit hit;

    #2 reset_n = 1'b0;
    repeat (3) tick();
    check_zero("reset");
    reset_n = 1'b1;
    tick();

    // T1: 2x2 basic capture
    d0 = n_done;
    start(2, 2);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_memrst", 64'(mem_reset), 64'd1);
    tick();
    chk("t1_memrst_pulse", 64'(mem_reset), 64'd0);
    send_m(0, 0, 3, 4); send_m(1, 0, 5, 4); send_m(0, 1, 7, 4); send_m(1, 1, 1, 4);
    wait_done("t1");
    repeat (3) tick();
    chk("t1_total16", 64'(total_count), 64'd16);
    chk("t1_done_once", 64'(n_done - d0), 64'd1);
    check_all("t1");

    // T2: preloaded bin accumulates
    start(2, 2);
    repeat (2) tick();
    preload(2, 10);
    send_m(0, 1, 4, 8);
    chk("t2_wr_addr", 64'(last_wr_addr), 64'd2);
    chk("t2_wr_val", 64'(last_wr_val), 64'd14);
    send_m(0, 0, 1, 4); send_m(1, 0, 2, 4); send_m(1, 1, 3, 4);
    wait_done("t2");
    check_all("t2");

    // T3a: 4 back-to-back strobes fit in the FIFO
    start(3, 2);
    repeat (2) tick();
    for (int k = 0; k < 4; k++) begin model_tuple(1, 1, 1); send(1, 1, 1); end
    repeat (16) tick();
    chk("t3a_ovf", 64'(overflow_err), 64'd0);
    chk("t3a_bin4", 64'(mem[4]), 64'd4);
    chk("t3a_bins", 64'(bins_received), 64'd4);
    send_m(0, 0, 2, 4); send_m(2, 1, 3, 4);
    wait_done("t3a");
    check_all("t3a");

    // T3b: 6 back-to-back strobes, the sixth is dropped
    start(4, 2);
    repeat (2) tick();
    for (int k = 0; k < 6; k++) begin
      if (k < 5) model_tuple(2, 1, 1);
      send(2, 1, 1);
    end
    repeat (20) tick();
    chk("t3b_ovf", 64'(overflow_err), 64'd1);
    chk("t3b_bins", 64'(bins_received), 64'd5);
    chk("t3b_bin6", 64'(mem[6]), 64'd5);
    send_m(0, 0, 1, 4); send_m(1, 0, 1, 4); send_m(3, 1, 1, 4);
    wait_done("t3b");
    check_all("t3b");

    // T4: out-of-range coordinates are dropped
    start(3, 2);
    repeat (2) tick();
    w0 = n_wr;
    send_m(3, 0, 5, 6);
    send_m(0, 2, 6, 6);
    chk("t4_rng", 64'(range_err), 64'd1);
    chk("t4_bins", 64'(bins_received), 64'd0);
    chk("t4_nowrite", 64'(n_wr - w0), 64'd0);
    for (int k = 0; k < 6; k++) send_m(k % 3, k / 3, k + 1, 4);
    wait_done("t4");
    check_all("t4");

    // T5: saturation
    start(1, 1);
    repeat (2) tick();
    preload(0, 16'hFFF0);
    send_m(0, 0, 16'h0020, 4);
    wait_done("t5");
    chk("t5_wr_val", 64'(last_wr_val), 64'hFFFF);
    check_all("t5");

    // zero bins: clear then done straight away
    start(0, 3);
    wait_done("zero");
    chk("zero_bins", 64'(bins_received), 64'd0);

    // randomized captures
    for (int r = 0; r < 4; r++) begin
      ni = $urandom_range(1, 4); nq = $urandom_range(1, 4);
      start(ni, nq);
      repeat (2) tick();
      for (int k = 0; k < ni * nq; k++) begin
        if ($urandom_range(0, 3) == 0)
          send_m(ni + $urandom_range(0, 2), $urandom_range(0, nq - 1), $urandom_range(0, 255), $urandom_range(3, 5));
        v = ($urandom_range(0, 3) == 0) ? $urandom_range(16'hC000, 16'hFFFF) : $urandom_range(0, 255);
        send_m($urandom_range(0, ni - 1), $urandom_range(0, nq - 1), v, $urandom_range(3, 5));
      end
      wait_done($sformatf("rnd%0d", r));
      chk($sformatf("rnd%0d_ovf", r), 64'(overflow_err), 64'd0);
      check_all($sformatf("rnd%0d", r));
    end

    // T6: asynchronous reset during the WAIT phase, then a fresh capture
    start(2, 2);
    repeat (2) tick();
    send(1, 1, 7);
    hit = 0;
    for (int c = 0; c < 10 && !hit; c++) begin
      if (mem_address == 16'd3 && !mem_write) hit = 1;
      else tick();
    end
    chk("t6_read_seen", 64'(hit), 64'd1);
    tick();
    #2 reset_n = 1'b0;
    #1 check_zero("t6_async");
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    start(1, 1);
    repeat (2) tick();
    send_m(0, 0, 9, 4);
    wait_done("t6");
    check_all("t6");

    chk("never_wr_and_rst", 64'(n_both), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
